// File: rtl/stack_mc_ctrl_if.sv
// Control bundle between the gen-2 stack-machine sequencer and its datapath:
// IR/stack status and memory handshake in, datapath strobes and fault status out.
interface stack_mc_ctrl_if #(
   parameter int OPCODE_W = 3,
   parameter int ALUOP_W  = 2
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                stk_empty;
   logic                stk_single;
   logic                stk_full;

   logic                iord;
   logic                src_a;
   logic                src_b;
   logic                ld_a;
   logic                ld_b;
   logic                pc_src;
   logic                pc_write;
   logic                mem_read;
   logic                ir_write;
   logic                tos;
   logic                pop;
   logic                push;
   logic                mtos;
   logic                pc_write_cond;
   logic                mem_write;
   logic [ALUOP_W-1:0]  alu_op;
   logic                fault;
   logic [1:0]          fault_code;

   modport master (
      input  opcode, mem_ready, stk_empty, stk_single, stk_full,
      output iord, src_a, src_b, ld_a, ld_b, pc_src, pc_write, mem_read, ir_write,
             tos, pop, push, mtos, pc_write_cond, mem_write, alu_op, fault, fault_code
   );

   modport slave (
      output opcode, mem_ready, stk_empty, stk_single, stk_full,
      input  iord, src_a, src_b, ld_a, ld_b, pc_src, pc_write, mem_read, ir_write,
             tos, pop, push, mtos, pc_write_cond, mem_write, alu_op, fault, fault_code
   );
endinterface

// File: rtl/stack_mc_ctrl.sv
// Gen-2 multicycle control FSM for the stack-machine CPU: memory wait states, stack checks,
// illegal-opcode detection and a sticky fault. MEM_TIMEOUT_EN enables the memory-access timeout.
module stack_mc_ctrl #(
   parameter int OPCODE_W     = 3,
   parameter int ALUOP_W      = 2,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic            clk,
   input  logic            rst,
   stack_mc_ctrl_if.master bus
);
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEM_RD   = 4'd2;
   localparam logic [3:0] S_PUSH_MEM = 4'd3;
   localparam logic [3:0] S_POP_A    = 4'd4;
   localparam logic [3:0] S_LOAD_A   = 4'd5;
   localparam logic [3:0] S_POP_B    = 4'd6;
   localparam logic [3:0] S_LOAD_B   = 4'd7;
   localparam logic [3:0] S_ALU1     = 4'd8;
   localparam logic [3:0] S_ALU2     = 4'd9;
   localparam logic [3:0] S_PUSH_RES = 4'd10;
   localparam logic [3:0] S_MEM_WR   = 4'd11;
   localparam logic [3:0] S_JUMP     = 4'd12;
   localparam logic [3:0] S_BRANCH   = 4'd13;
   localparam logic [3:0] S_FAULT    = 4'd14;

   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_PUSH = 3'b100;
   localparam logic [2:0] OP_POP  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_JZ   = 3'b111;

   localparam logic [1:0] FC_ILLEGAL   = 2'b00;
   localparam logic [1:0] FC_OVERFLOW  = 2'b01;
   localparam logic [1:0] FC_UNDERFLOW = 2'b10;
   localparam logic [1:0] FC_TIMEOUT   = 2'b11;

   logic [3:0] state_r;
   logic [3:0] state_nxt_s;
   logic [1:0] code_r;
   logic [1:0] code_nxt_s;
   logic [2:0] op_s;
   logic       upper_bad_s;
   logic       underflow_s;
   logic       wait_max_s;

   assign op_s        = bus.opcode[2:0];
   assign upper_bad_s = ((bus.opcode >> 3'd3) != {OPCODE_W{1'b0}});
   // Binary ops need two operands; not and pop-to-mem need one.
   assign underflow_s = (bus.stk_empty  && (!op_s[2] || (op_s == OP_POP))) ||
                        (bus.stk_single && !op_s[2] && (op_s != OP_NOT));

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

   logic [CNT_W-1:0] wait_cnt_r;
   logic             mem_access_s;

   assign mem_access_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
   assign wait_max_s   = (wait_cnt_r == CNT_W'(MEM_WAIT_MAX));

   // Wait-state counter: cleared on every state entry, counts mem_ready-low cycles of an access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (state_nxt_s != state_r) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (mem_access_s && !bus.mem_ready) begin
         wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end
`else
   assign wait_max_s = 1'b0;
`endif

   // State and sticky fault-code registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_FETCH;
         code_r  <= FC_ILLEGAL;
      end else begin
         state_r <= state_nxt_s;
         code_r  <= code_nxt_s;
      end
   end

   // Next-state decode; the fault code is latched on the transition into FAULT.
   always_comb begin
      state_nxt_s = state_r;
      code_nxt_s  = code_r;
      case (state_r)
         S_FETCH, S_MEM_RD, S_MEM_WR: begin
            if (bus.mem_ready) begin
               if (state_r == S_FETCH) begin
                  state_nxt_s = S_DECODE;
               end else if (state_r == S_MEM_RD) begin
                  state_nxt_s = S_PUSH_MEM;
               end else begin
                  state_nxt_s = S_FETCH;
               end
            end else if (wait_max_s) begin
               state_nxt_s = S_FAULT;
               code_nxt_s  = FC_TIMEOUT;
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_DECODE: begin
            if (upper_bad_s) begin
               state_nxt_s = S_FAULT;
               code_nxt_s  = FC_ILLEGAL;
            end else if ((op_s == OP_PUSH) && bus.stk_full) begin
               state_nxt_s = S_FAULT;
               code_nxt_s  = FC_OVERFLOW;
            end else if (underflow_s) begin
               state_nxt_s = S_FAULT;
               code_nxt_s  = FC_UNDERFLOW;
            end else begin
               case (op_s)
                  OP_PUSH: state_nxt_s = S_MEM_RD;
                  OP_JMP:  state_nxt_s = S_JUMP;
                  OP_JZ:   state_nxt_s = S_BRANCH;
                  default: state_nxt_s = S_POP_A;
               endcase
            end
         end
         S_PUSH_MEM: state_nxt_s = S_FETCH;
         S_POP_A:    state_nxt_s = S_LOAD_A;
         S_LOAD_A: begin
            if (op_s == OP_POP) begin
               state_nxt_s = S_MEM_WR;
            end else if (op_s == OP_NOT) begin
               state_nxt_s = S_ALU1;
            end else begin
               state_nxt_s = S_POP_B;
            end
         end
         S_POP_B:    state_nxt_s = S_LOAD_B;
         S_LOAD_B:   state_nxt_s = S_ALU2;
         S_ALU1:     state_nxt_s = S_PUSH_RES;
         S_ALU2:     state_nxt_s = S_PUSH_RES;
         S_PUSH_RES: state_nxt_s = S_FETCH;
         S_JUMP:     state_nxt_s = S_FETCH;
         S_BRANCH:   state_nxt_s = S_FETCH;
         S_FAULT:    state_nxt_s = S_FAULT;
         default: begin
            // A corrupted state encoding is treated as a hard fault.
            state_nxt_s = S_FAULT;
            code_nxt_s  = FC_ILLEGAL;
         end
      endcase
   end

   // Moore strobe decode; only FETCH's pc_write/ir_write follow mem_ready.
   always_comb begin
      bus.iord          = 1'b0;
      bus.src_a         = 1'b0;
      bus.src_b         = 1'b0;
      bus.ld_a          = 1'b0;
      bus.ld_b          = 1'b0;
      bus.pc_src        = 1'b0;
      bus.pc_write      = 1'b0;
      bus.mem_read      = 1'b0;
      bus.ir_write      = 1'b0;
      bus.tos           = 1'b0;
      bus.pop           = 1'b0;
      bus.push          = 1'b0;
      bus.mtos          = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.mem_write     = 1'b0;
      bus.alu_op        = {ALUOP_W{1'b0}};
      case (state_r)
         S_FETCH: begin
            bus.mem_read = 1'b1;
            bus.pc_write = bus.mem_ready;
            bus.ir_write = bus.mem_ready;
         end
         S_DECODE:   bus.tos = 1'b1;
         S_MEM_RD: begin
            bus.iord     = 1'b1;
            bus.mem_read = 1'b1;
         end
         S_PUSH_MEM: begin
            bus.mtos = 1'b1;
            bus.push = 1'b1;
         end
         S_POP_A:    bus.pop  = 1'b1;
         S_LOAD_A:   bus.ld_a = 1'b1;
         S_POP_B:    bus.pop  = 1'b1;
         S_LOAD_B:   bus.ld_b = 1'b1;
         S_ALU1:     bus.alu_op = ALUOP_W'(2'd3);
         S_ALU2:     bus.alu_op = ALUOP_W'(op_s[1:0]);
         S_PUSH_RES: bus.push = 1'b1;
         S_MEM_WR: begin
            bus.iord      = 1'b1;
            bus.mem_write = 1'b1;
         end
         S_JUMP: begin
            bus.pc_src   = 1'b1;
            bus.pc_write = 1'b1;
         end
         S_BRANCH: begin
            bus.pc_src        = 1'b1;
            bus.pc_write_cond = 1'b1;
         end
         default: bus.tos = 1'b0;
      endcase
   end

   assign bus.fault      = (state_r == S_FAULT);
   assign bus.fault_code = code_r;
endmodule

// File: tb/tb_stack_mc_ctrl.sv
// Table-driven bench for stack_mc_ctrl (OPCODE_W=4, MEM_WAIT_MAX=4); honours MEM_TIMEOUT_EN.
module tb_stack_mc_ctrl;
   localparam int OPW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stack_mc_ctrl_if #(.OPCODE_W(OPW), .ALUOP_W(2)) bus_i ();

   stack_mc_ctrl #(.OPCODE_W(OPW), .ALUOP_W(2), .MEM_WAIT_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] op;
      logic       e, s, f;
      int         cyc, pops, pushes, mtos, memwr, pcsrc, cond, alu;
      int         flt, code;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // All strobes plus fault status; reset/idle FETCH with mem_ready=0 reads 20'h01000.
   function automatic logic [19:0] outs();
      return {bus_i.iord, bus_i.src_a, bus_i.src_b, bus_i.ld_a, bus_i.ld_b, bus_i.pc_src,
              bus_i.pc_write, bus_i.mem_read, bus_i.ir_write, bus_i.tos, bus_i.pop, bus_i.push,
              bus_i.mtos, bus_i.pc_write_cond, bus_i.mem_write, bus_i.alu_op, bus_i.fault,
              bus_i.fault_code};
   endfunction

   // Leaves the bench at a falling edge with rst just released and the DUT in FETCH.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_in(input logic [3:0] op, input logic e, input logic s, input logic f);
      bus_i.opcode     = op;
      bus_i.stk_empty  = e;
      bus_i.stk_single = s;
      bus_i.stk_full   = f;
   endtask

   initial begin
      int cyc, pops, pushes, mtos, memwr, pcsrc, cond, alu, first_flt;
      int rd_cnt, pm_cnt, fetch_cnt;

      //            op      e     s     f    cyc pop psh mtos mw pcs cnd alu flt code
      vecs[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 8, 2, 1, 0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 8, 2, 1, 0, 0, 0, 0, 1, 0, 0};
      vecs[2]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 8, 2, 1, 0, 0, 0, 0, 2, 0, 0};
      vecs[3]  = '{4'b0011, 1'b0, 1'b1, 1'b0, 6, 1, 1, 0, 0, 0, 0, 3, 0, 0};
      vecs[4]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4, 0, 1, 1, 0, 0, 0, 0, 0, 0};
      vecs[5]  = '{4'b0101, 1'b0, 1'b1, 1'b0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0};
      vecs[6]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      vecs[7]  = '{4'b0111, 1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0};
      vecs[8]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[9]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
      vecs[10] = '{4'b0101, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
      vecs[11] = '{4'b1000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vecs[12] = '{4'b1111, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vecs[13] = '{4'b0010, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
      vecs[14] = '{4'b0100, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[15] = '{4'b0011, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2};

      set_in(4'b0000, 1'b0, 1'b0, 1'b0);
      bus_i.mem_ready = 1'b0;
      #2;
      chk("reset_outs_initial", int'(outs()), 32'h0000_1000);

      for (int v = 0; v < 16; v++) begin
         set_in(vecs[v].op, vecs[v].e, vecs[v].s, vecs[v].f);
         do_reset();
         cyc = 0; pops = 0; pushes = 0; mtos = 0; memwr = 0;
         pcsrc = 0; cond = 0; alu = 0; first_flt = 0;
         for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            bus_i.mem_ready = 1'b1;
            #1;
            if (c > 1 && bus_i.ir_write) begin
               cyc = c - 1;
               break;
            end
            pops   += int'(bus_i.pop);
            pushes += int'(bus_i.push);
            mtos   += int'(bus_i.mtos);
            memwr  += int'(bus_i.mem_write);
            pcsrc  += int'(bus_i.pc_src);
            cond   += int'(bus_i.pc_write_cond);
            alu    |= int'(bus_i.alu_op);
            if (bus_i.fault && first_flt == 0) first_flt = c;
         end
         chk($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
         chk($sformatf("v%0d_pops", v), pops, vecs[v].pops);
         chk($sformatf("v%0d_pushes", v), pushes, vecs[v].pushes);
         chk($sformatf("v%0d_mtos", v), mtos, vecs[v].mtos);
         chk($sformatf("v%0d_mem_write", v), memwr, vecs[v].memwr);
         chk($sformatf("v%0d_pc_src", v), pcsrc, vecs[v].pcsrc);
         chk($sformatf("v%0d_pc_write_cond", v), cond, vecs[v].cond);
         chk($sformatf("v%0d_alu_op", v), alu, vecs[v].alu);
         chk($sformatf("v%0d_fault", v), int'(bus_i.fault), vecs[v].flt);
         chk($sformatf("v%0d_fault_code", v), int'(bus_i.fault_code), vecs[v].code);
         chk($sformatf("v%0d_fault_cycle", v), first_flt, (vecs[v].flt != 0) ? 3 : 0);
         chk($sformatf("v%0d_mem_read_end", v), int'(bus_i.mem_read), (vecs[v].flt != 0) ? 0 : 1);
      end

      // Reset out of a sticky underflow fault clears everything.
      @(negedge clk);
      bus_i.mem_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("reset_outs_from_fault", int'(outs()), 32'h0000_1000);
      @(negedge clk);
      rst = 1'b0;

      // push with three wait states in MEM_RD
      set_in(4'b0100, 1'b0, 1'b0, 1'b0);
      do_reset();
      rd_cnt = 0; pm_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) @(negedge clk);
         bus_i.mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
         #1;
         if (c == 8) begin
            chk("push_wait_refetch", int'(bus_i.ir_write), 1);
         end else begin
            rd_cnt += int'(bus_i.iord && bus_i.mem_read);
            pm_cnt += int'(bus_i.mtos && bus_i.push);
         end
      end
      chk("push_wait_rd_cycles", rd_cnt, 4);
      chk("push_wait_mtos_push", pm_cnt, 1);
      chk("push_wait_no_fault", int'(bus_i.fault), 0);

      // FETCH with mem_ready stuck low
      set_in(4'b0000, 1'b0, 1'b0, 1'b0);
      do_reset();
      fetch_cnt = 0;
`ifdef MEM_TIMEOUT_EN
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) @(negedge clk);
         bus_i.mem_ready = 1'b0;
         #1;
         fetch_cnt += int'(bus_i.mem_read && !bus_i.iord);
      end
      chk("timeout_fetch_cycles", fetch_cnt, 5);
      chk("timeout_fault", int'(bus_i.fault), 1);
      chk("timeout_code", int'(bus_i.fault_code), 3);
`else
      for (int c = 1; c <= 100; c++) begin
         if (c > 1) @(negedge clk);
         bus_i.mem_ready = 1'b0;
         #1;
         fetch_cnt += int'(bus_i.mem_read && !bus_i.iord);
      end
      chk("no_timeout_fetch_cycles", fetch_cnt, 100);
      chk("no_timeout_fault", int'(bus_i.fault), 0);
`endif

      // rst mid MEM_WR drops mem_write without waiting for the clock
      set_in(4'b0101, 1'b0, 1'b1, 1'b0);
      do_reset();
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) @(negedge clk);
         bus_i.mem_ready = (c == 5) ? 1'b0 : 1'b1;
         #1;
      end
      chk("memwr_before_rst", int'(bus_i.mem_write && bus_i.iord), 1);
      #1;
      rst = 1'b1;
      #1;
      chk("memwr_async_rst_outs", int'(outs()), 32'h0000_1000);
      @(negedge clk);
      rst = 1'b0;
      bus_i.mem_ready = 1'b1;
      #1;
      chk("memwr_rst_refetch", int'(bus_i.ir_write), 1);
      chk("memwr_rst_no_write", int'(bus_i.mem_write), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
